// File: rtl/snn_delay_core_pkg.sv
// Shared constants and synapse index helpers for the snn_delay_core datapath.
// Topology: 24 inputs -> 8 hidden LIF neurons -> 2 output LIF neurons.
// Optional feature macro: SNN_REFRACTORY_EN (see lif_neuron).
package snn_pkg;

   localparam int N_IN       = 24;
   localparam int N_HID      = 8;
   localparam int N_OUT      = 2;
   localparam int W_BITS     = 8;
   localparam int D_BITS     = 4;
   localparam int HIST_DEPTH = 16;
   localparam int N_SYN      = N_IN * N_HID + N_HID * N_OUT;

   // Flat synapse index of input i -> hidden j.
   function automatic int syn_idx_hid(input int i, input int j);
      return j * N_IN + i;
   endfunction

   // Flat synapse index of hidden j -> output k.
   function automatic int syn_idx_out(input int j, input int k);
      return N_IN * N_HID + k * N_HID + j;
   endfunction

endpackage

// File: rtl/snn_delay_core_lif_neuron.sv
// Single leaky integrate-and-fire neuron with a parameterised fan-in.
// Holds its membrane potential, refractory counter and spike register.
// Macro SNN_REFRACTORY_EN: when defined, a refractory counter silences the
// neuron for refractory_period timesteps after each spike; when undefined
// the counter does not exist and the neuron may fire every timestep.
module lif_neuron
   import snn_pkg::*;
#(
   parameter int FAN_IN = 24
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_step,
   input  logic [FAN_IN-1:0]          i_spikes,
   input  logic [FAN_IN*W_BITS-1:0]   i_weights,
   input  logic [7:0]                 i_threshold,
   input  logic [7:0]                 i_decay,
   input  logic [7:0]                 i_refractory_period,
   output logic [7:0]                 o_v,
   output logic                       o_spike
);

   logic [7:0]         r_v;
   logic               r_spike;
   logic signed [15:0] w_acc;
   logic [7:0]         w_leak;
   logic signed [16:0] w_sum;
   logic [7:0]         w_v_new;
   logic               w_fire;

`ifdef SNN_REFRACTORY_EN
   logic [7:0]         r_refr;
`else
   logic               w_unused_refr;
   assign w_unused_refr = ^i_refractory_period;
`endif

   // Sum the signed weights of all synapses whose delayed spike is set.
   always_comb begin
      w_acc = 16'sd0;
      for (int i = 0; i < FAN_IN; i++) begin
         if (i_spikes[i]) begin
            w_acc = w_acc + $signed({{(16-W_BITS){i_weights[i*W_BITS+W_BITS-1]}},
                                     i_weights[i*W_BITS +: W_BITS]});
         end else begin
            w_acc = w_acc;
         end
      end
   end

   // Leak toward zero, add the weighted input and clamp into 0..255.
   always_comb begin
      if (r_v > i_decay) begin
         w_leak = r_v - i_decay;
      end else begin
         w_leak = 8'd0;
      end
      w_sum = $signed({9'd0, w_leak}) + $signed({w_acc[15], w_acc});
      if (w_sum < 17'sd0) begin
         w_v_new = 8'd0;
      end else if (w_sum > 17'sd255) begin
         w_v_new = 8'hFF;
      end else begin
         w_v_new = w_sum[7:0];
      end
      w_fire = (w_v_new >= i_threshold);
   end

   // Commit potential, spike and refractory state once per timestep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v     <= 8'd0;
         r_spike <= 1'b0;
`ifdef SNN_REFRACTORY_EN
         r_refr  <= 8'd0;
`endif
      end else if (i_step) begin
`ifdef SNN_REFRACTORY_EN
         // A refractory neuron stays silent even when over threshold.
         if (r_refr != 8'd0) begin
            r_v     <= 8'd0;
            r_refr  <= r_refr - 8'd1;
            r_spike <= 1'b0;
         end else if (w_fire) begin
            r_v     <= 8'd0;
            r_refr  <= i_refractory_period;
            r_spike <= 1'b1;
         end else begin
            r_v     <= w_v_new;
            r_spike <= 1'b0;
         end
`else
         if (w_fire) begin
            r_v     <= 8'd0;
            r_spike <= 1'b1;
         end else begin
            r_v     <= w_v_new;
            r_spike <= 1'b0;
         end
`endif
      end
   end

   assign o_v     = r_v;
   assign o_spike = r_spike;

endmodule

// File: rtl/snn_delay_core.sv
// Two-layer LIF spiking core (24 -> 8 -> 2) with per-synapse axonal delays.
// Each presynaptic source keeps a 16-deep spike history; a synapse with
// delay d reads its source at depth d after the current timestep's shift.
// Hidden spikes enter their history from the registered layer-1 outputs,
// giving an inherent one-timestep hidden-to-output latency.
// Macro SNN_REFRACTORY_EN enables per-neuron refractory counters.
module snn_delay_core
   import snn_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       delay_clk,
   input  logic [N_IN-1:0]            input_spikes,
   input  logic [N_SYN*W_BITS-1:0]    weights,
   input  logic [7:0]                 threshold,
   input  logic [7:0]                 decay,
   input  logic [7:0]                 refractory_period,
   input  logic [N_SYN*D_BITS-1:0]    delays,
   output logic [(N_HID+N_OUT)*8-1:0] membrane_potential_out,
   output logic [N_HID-1:0]           output_spikes_layer1,
   output logic [N_OUT-1:0]           output_spikes
);

   logic                  r_dclk_prev;
   logic                  w_step;
   logic [HIST_DEPTH-1:0] r_in_hist      [N_IN];
   logic [HIST_DEPTH-1:0] r_hid_hist     [N_HID];
   logic [HIST_DEPTH-1:0] w_in_hist_nxt  [N_IN];
   logic [HIST_DEPTH-1:0] w_hid_hist_nxt [N_HID];
   logic [N_IN-1:0]       w_hid_dspk     [N_HID];
   logic [N_HID-1:0]      w_out_dspk     [N_OUT];
   logic [N_HID-1:0]      w_l1_spk;
   logic [N_OUT-1:0]      w_l2_spk;

   // Rising-edge detect on the timestep strobe; edges seen while disabled are dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dclk_prev <= 1'b0;
      end else begin
         r_dclk_prev <= delay_clk;
      end
   end

   assign w_step = enable & delay_clk & ~r_dclk_prev;

   // Shifted histories as they will look after this timestep.
   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         w_in_hist_nxt[i] = {r_in_hist[i][HIST_DEPTH-2:0], input_spikes[i]};
      end
      for (int j = 0; j < N_HID; j++) begin
         w_hid_hist_nxt[j] = {r_hid_hist[j][HIST_DEPTH-2:0], w_l1_spk[j]};
      end
   end

   // Advance the spike histories on each executed timestep.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_IN; i++) begin
            r_in_hist[i] <= '0;
         end
         for (int j = 0; j < N_HID; j++) begin
            r_hid_hist[j] <= '0;
         end
      end else if (w_step) begin
         for (int i = 0; i < N_IN; i++) begin
            r_in_hist[i] <= w_in_hist_nxt[i];
         end
         for (int j = 0; j < N_HID; j++) begin
            r_hid_hist[j] <= w_hid_hist_nxt[j];
         end
      end
   end

   // Pick each synapse's delayed spike from its source history.
   always_comb begin
      for (int j = 0; j < N_HID; j++) begin
         for (int i = 0; i < N_IN; i++) begin
            w_hid_dspk[j][i] =
               w_in_hist_nxt[i][delays[syn_idx_hid(i, j)*D_BITS +: D_BITS]];
         end
      end
      for (int k = 0; k < N_OUT; k++) begin
         for (int j = 0; j < N_HID; j++) begin
            w_out_dspk[k][j] =
               w_hid_hist_nxt[j][delays[syn_idx_out(j, k)*D_BITS +: D_BITS]];
         end
      end
   end

   for (genvar j = 0; j < N_HID; j++) begin : g_hid
      lif_neuron #(.FAN_IN(N_IN)) u_neuron (
         .clk                 (clk),
         .rst_n               (reset),
         .i_step              (w_step),
         .i_spikes            (w_hid_dspk[j]),
         .i_weights           (weights[j*N_IN*W_BITS +: N_IN*W_BITS]),
         .i_threshold         (threshold),
         .i_decay             (decay),
         .i_refractory_period (refractory_period),
         .o_v                 (membrane_potential_out[j*8 +: 8]),
         .o_spike             (w_l1_spk[j])
      );
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      lif_neuron #(.FAN_IN(N_HID)) u_neuron (
         .clk                 (clk),
         .rst_n               (reset),
         .i_step              (w_step),
         .i_spikes            (w_out_dspk[k]),
         .i_weights           (weights[(N_IN*N_HID + k*N_HID)*W_BITS +: N_HID*W_BITS]),
         .i_threshold         (threshold),
         .i_decay             (decay),
         .i_refractory_period (refractory_period),
         .o_v                 (membrane_potential_out[(N_HID+k)*8 +: 8]),
         .o_spike             (w_l2_spk[k])
      );
   end

   assign output_spikes_layer1 = w_l1_spk;
   assign output_spikes        = w_l2_spk;

endmodule

// File: tb/tb_snn_delay_core.sv
// Directed self-checking bench for snn_delay_core.
module tb_snn_delay_core;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          delay_clk;
   logic [23:0]   input_spikes;
   logic [1663:0] weights;
   logic [7:0]    threshold;
   logic [7:0]    decay;
   logic [7:0]    refractory_period;
   logic [831:0]  delays;
   logic [79:0]   membrane_potential_out;
   logic [7:0]    output_spikes_layer1;
   logic [1:0]    output_spikes;

   int errors = 0;
   int checks = 0;

   snn_delay_core dut (
      .clk                    (clk),
      .reset                  (reset),
      .enable                 (enable),
      .delay_clk              (delay_clk),
      .input_spikes           (input_spikes),
      .weights                (weights),
      .threshold              (threshold),
      .decay                  (decay),
      .refractory_period      (refractory_period),
      .delays                 (delays),
      .membrane_potential_out (membrane_potential_out),
      .output_spikes_layer1   (output_spikes_layer1),
      .output_spikes          (output_spikes)
   );

   always #5 clk = ~clk;

   // One delay_clk pulse; the timestep runs on the posedge inside it, sampling at a negedge.
   task automatic step();
      @(negedge clk) delay_clk = 1'b1;
      @(negedge clk) delay_clk = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b0;
      delay_clk = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic cfg_clear();
      weights           = '0;
      delays            = '0;
      threshold         = 8'd0;
      decay             = 8'd0;
      refractory_period = 8'd0;
      input_spikes      = 24'd0;
      enable            = 1'b1;
   endtask

   task automatic cfg_all_fire(input logic [7:0] refr);
      cfg_clear();
      weights           = {208{8'h7F}};
      threshold         = 8'h1A;
      decay             = 8'h2B;
      refractory_period = refr;
      input_spikes      = 24'hABCDEF;
   endtask

   task automatic test_reset();
      cfg_clear();
      do_reset();
      checks++;
      if (membrane_potential_out !== 80'h0) begin
         $display("FAIL reset_v got=%h exp=0", membrane_potential_out);
         errors++;
      end
      checks++;
      if (output_spikes_layer1 !== 8'h00) begin
         $display("FAIL reset_l1 got=%h exp=00", output_spikes_layer1);
         errors++;
      end
      checks++;
      if (output_spikes !== 2'b00) begin
         $display("FAIL reset_out got=%b exp=00", output_spikes);
         errors++;
      end
   endtask

   task automatic test_all_fire();
      cfg_all_fire(8'h00);
      do_reset();
      step();
      checks++;
      if (output_spikes_layer1 !== 8'hFF) begin
         $display("FAIL fire_s1_l1 got=%h exp=ff", output_spikes_layer1);
         errors++;
      end
      checks++;
      if (output_spikes !== 2'b00) begin
         $display("FAIL fire_s1_out got=%b exp=00", output_spikes);
         errors++;
      end
      checks++;
      if (membrane_potential_out !== 80'h0) begin
         $display("FAIL fire_s1_v got=%h exp=0", membrane_potential_out);
         errors++;
      end
      for (int s = 2; s <= 5; s++) begin
         step();
         checks++;
         if (output_spikes !== 2'b11) begin
            $display("FAIL fire_out step=%0d got=%b exp=11", s, output_spikes);
            errors++;
         end
      end
   endtask

   task automatic test_refractory();
      logic [7:0] exp_l1;
      cfg_all_fire(8'h3C);
      do_reset();
      for (int s = 1; s <= 62; s++) begin
         step();
`ifdef SNN_REFRACTORY_EN
         exp_l1 = (s == 1 || s == 62) ? 8'hFF : 8'h00;
`else
         exp_l1 = 8'hFF;
`endif
         checks++;
         if (output_spikes_layer1 !== exp_l1) begin
            $display("FAIL refr_l1 step=%0d got=%h exp=%h", s, output_spikes_layer1, exp_l1);
            errors++;
         end
      end
   endtask

   task automatic test_delay();
      logic [7:0] exp_l1;
      cfg_clear();
      weights[7:0] = 8'h7F;
      delays[3:0]  = 4'd5;
      threshold    = 8'd100;
      do_reset();
      for (int s = 1; s <= 8; s++) begin
         input_spikes = (s == 1) ? 24'd1 : 24'd0;
         step();
         exp_l1 = (s == 6) ? 8'h01 : 8'h00;
         checks++;
         if (output_spikes_layer1 !== exp_l1) begin
            $display("FAIL delay_l1 step=%0d got=%h exp=%h", s, output_spikes_layer1, exp_l1);
            errors++;
         end
      end
   endtask

   task automatic test_leak();
      logic [7:0] exp_v [6] = '{8'h40, 8'h70, 8'hA0, 8'hD0, 8'h00, 8'h40};
      logic       exp_s [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      cfg_clear();
      weights[7:0] = 8'h40;
      threshold    = 8'hFF;
      decay        = 8'h10;
      input_spikes = 24'd1;
      do_reset();
      for (int s = 0; s < 6; s++) begin
         step();
         checks++;
         if (membrane_potential_out[7:0] !== exp_v[s]) begin
            $display("FAIL leak_v step=%0d got=%h exp=%h", s + 1, membrane_potential_out[7:0], exp_v[s]);
            errors++;
         end
         checks++;
         if (output_spikes_layer1[0] !== exp_s[s]) begin
            $display("FAIL leak_s step=%0d got=%b exp=%b", s + 1, output_spikes_layer1[0], exp_s[s]);
            errors++;
         end
      end
   endtask

   task automatic test_negative_and_enable();
      cfg_clear();
      weights[7:0] = 8'h80;
      threshold    = 8'hFF;
      input_spikes = 24'd1;
      do_reset();
      for (int s = 1; s <= 3; s++) begin
         step();
         checks++;
         if (membrane_potential_out[7:0] !== 8'h00) begin
            $display("FAIL neg_v step=%0d got=%h exp=00", s, membrane_potential_out[7:0]);
            errors++;
         end
      end
      weights[7:0] = 8'h40;
      step();
      step();
      checks++;
      if (membrane_potential_out[7:0] !== 8'h80) begin
         $display("FAIL preload_v got=%h exp=80", membrane_potential_out[7:0]);
         errors++;
      end
      enable = 1'b0;
      for (int s = 0; s < 3; s++) begin
         step();
      end
      checks++;
      if (membrane_potential_out[7:0] !== 8'h80) begin
         $display("FAIL hold_v got=%h exp=80", membrane_potential_out[7:0]);
         errors++;
      end
      enable = 1'b1;
      @(negedge clk);
      checks++;
      if (membrane_potential_out[7:0] !== 8'h80) begin
         $display("FAIL no_queue_v got=%h exp=80", membrane_potential_out[7:0]);
         errors++;
      end
      step();
      checks++;
      if (membrane_potential_out[7:0] !== 8'hC0) begin
         $display("FAIL resume_v got=%h exp=c0", membrane_potential_out[7:0]);
         errors++;
      end
   endtask

   task automatic test_thr_zero();
      cfg_clear();
      do_reset();
      step();
      checks++;
      if (output_spikes_layer1 !== 8'hFF) begin
         $display("FAIL thr0_l1 got=%h exp=ff", output_spikes_layer1);
         errors++;
      end
      checks++;
      if (output_spikes !== 2'b11) begin
         $display("FAIL thr0_out got=%b exp=11", output_spikes);
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      cfg_all_fire(8'h00);
      do_reset();
      step();
      step();
      step();
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (output_spikes !== 2'b00 || output_spikes_layer1 !== 8'h00 ||
          membrane_potential_out !== 80'h0) begin
         $display("FAIL midreset got=%b/%h/%h exp=0", output_spikes, output_spikes_layer1,
                  membrane_potential_out);
         errors++;
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      step();
      checks++;
      if (output_spikes_layer1 !== 8'hFF) begin
         $display("FAIL midreset_l1 got=%h exp=ff", output_spikes_layer1);
         errors++;
      end
      checks++;
      if (output_spikes !== 2'b00) begin
         $display("FAIL midreset_out got=%b exp=00", output_spikes);
         errors++;
      end
   endtask

   initial begin
      reset     = 1'b0;
      delay_clk = 1'b0;
      cfg_clear();
      test_reset();
      test_all_fire();
      test_refractory();
      test_delay();
      test_leak();
      test_negative_and_enable();
      test_thr_zero();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
